// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the XOR network layers.
// Contents: default data/fraction widths, the fx_t sample type, activation
// selector enum, FSM state enum, and the sat()/act() helpers that every
// layer applies to its biased sums.
package nn_pkg;

    localparam int DW_DEF   = 8;
    localparam int FRAC_DEF = 4;

    typedef logic signed [DW_DEF-1:0] fx_t;

    typedef enum int {
        ACT_IDENT = 0,
        ACT_RELU  = 1,
        ACT_HSIG  = 2
    } act_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_BIAS = 3'd2,
        ST_ACT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Clamp x into the signed range of a dw-bit word.
    function automatic int sat(input int x, input int dw);
        int hi;
        int lo;
        int r;
        hi = (1 << (dw - 1)) - 1;
        lo = -(1 << (dw - 1));
        r  = x;
        if (x > hi) r = hi;
        if (x < lo) r = lo;
        return r;
    endfunction

    // Activation on a saturated sum. Hard sigmoid is a slope-1/4 line centred
    // on 0.5 and clamped to [0, 1.0] in the fixed-point format.
    function automatic int act(input int s, input int mode, input int frac);
        int r;
        int one;
        one = 1 << frac;
        r   = s;
        if (mode == int'(ACT_RELU)) begin
            r = (s < 0) ? 0 : s;
        end else if (mode == int'(ACT_HSIG)) begin
            r = (s >>> 2) + one / 2;
            if (r < 0)   r = 0;
            if (r > one) r = one;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_output_layer_if.sv
// Valid/ready handshake bundle around nn_output_layer.
//   in_valid/in_ready/in_data    : activations arriving from layer0
//   out_valid/out_ready/out_data : activated results to the consumer
// master = upstream producer plus downstream consumer; slave = the layer.
interface nn_output_layer_if
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int DW    = DW_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*DW-1:0]    in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT*DW-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/nn_weight_rom.sv
// Constant weight table with a registered read port.
//   clk, rst : clock, asynchronous active-low reset
//   addr     : input index k
//   row      : weights w[j][addr] of every neuron j, neuron 0 in LSBs;
//              valid one cycle after addr. Out-of-range addr reads zero.
module nn_weight_rom
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int DW    = DW_DEF,
    parameter int KW    = $clog2(N_IN + 1),
    parameter logic [N_OUT*N_IN*DW-1:0] W_INIT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KW-1:0]       addr,
    output logic [N_OUT*DW-1:0] row
);
    logic [N_OUT*DW-1:0] row_d;

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        row_d = '0;
        if (int'(addr) < N_IN) begin
            for (int j = 0; j < N_OUT; j++) begin
                row_d[j*DW +: DW] = W_INIT[(j*N_IN + int'(addr))*DW +: DW];
            end
        end
    end

    // NOTE: the table itself is a parameter, not storage, so only the read register needs a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
        end else begin
            // NOTE: sequential state is updated with <= so every register samples pre-edge values.
            row <= row_d;
        end
    end

endmodule

// File: rtl/nn_output_layer.sv
// Fully-connected output layer of the fixed-point XOR network.
// Accepts N_IN activations, runs one multiply-accumulate per input per cycle
// for all N_OUT neurons in parallel, adds the bias, saturates, applies the
// activation and presents the result on a valid/ready output.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : nn_output_layer_if.slave (in_* from layer0, out_* to consumer)
//   busy : high whenever the FSM is not idle
module nn_output_layer
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACT   = int'(ACT_HSIG),
    parameter logic [N_OUT*N_IN*DW-1:0] W_INIT = '0,
    parameter logic [N_OUT*DW-1:0]      B_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    nn_output_layer_if.slave bus,
    output logic             busy
);
    localparam int KW = $clog2(N_IN + 1);
    localparam int AW = 2*DW + KW;

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_MAC  = ST_MAC;
    localparam logic [2:0] S_BIAS = ST_BIAS;
    localparam logic [2:0] S_ACT  = ST_ACT;
    localparam logic [2:0] S_DONE = ST_DONE;

    logic [2:0]             state;
    logic [KW-1:0]          k;
    logic [KW-1:0]          rom_addr;
    logic                   last_k;
    logic [N_IN*DW-1:0]     a_q;
    logic [N_OUT*DW-1:0]    w_row;
    logic signed [DW-1:0]   a_k;
    logic signed [DW-1:0]   w_jk   [N_OUT];
    logic signed [2*DW-1:0] prod   [N_OUT];
    logic signed [AW-1:0]   term   [N_OUT];
    logic signed [AW-1:0]   biased [N_OUT];
    logic signed [AW-1:0]   acc    [N_OUT];
    logic [N_OUT*DW-1:0]    act_d;
    logic [N_OUT*DW-1:0]    out_q;
    logic                   out_valid_q;

    // Row 0 is fetched while idle so it is ready on the first MAC edge; each
    // MAC edge then consumes row k and fetches row k+1.
    assign rom_addr = (state == S_MAC) ? k + KW'(1) : '0;
    assign last_k   = (int'(k) == N_IN - 1);

    nn_weight_rom #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DW     (DW),
        .KW     (KW),
        .W_INIT (W_INIT)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .row  (w_row)
    );

    always_comb begin
        a_k   = a_q[DW-1:0];
        act_d = '0;
        if (int'(k) < N_IN) a_k = a_q[int'(k)*DW +: DW];
        for (int j = 0; j < N_OUT; j++) begin
            w_jk[j]   = w_row[j*DW +: DW];
            // Full-width signed product, then floor shift back to the data format.
            prod[j]   = (2*DW)'(a_k) * (2*DW)'(w_jk[j]);
            term[j]   = AW'(prod[j] >>> FRAC);
            biased[j] = AW'(sat(int'(acc[j]) + int'(signed'(B_INIT[j*DW +: DW])), DW));
            act_d[j*DW +: DW] = DW'(act(int'(acc[j]), ACT, FRAC));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            k           <= '0;
            a_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_data;
                        k     <= '0;
                        state <= S_MAC;
                        for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
                    end
                end
                S_MAC: begin
                    for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + term[j];
                    k <= k + KW'(1);
                    if (last_k) state <= S_BIAS;
                end
                S_BIAS: begin
                    // acc now holds the saturated, biased sum for the ACT step.
                    for (int j = 0; j < N_OUT; j++) acc[j] <= biased[j];
                    state <= S_ACT;
                end
                S_ACT: begin
                    out_q       <= act_d;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    // New input is only taken back in IDLE, never on the draining edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_nn_output_layer.sv
// Self-checking bench for nn_output_layer. Four instances share one stimulus:
//   dut 0: ACT identity, W=(24,-20), B=-4
//   dut 1: ACT identity, W=(127,127), B=0
//   dut 2: ACT ReLU,     W=(127,127), B=0
//   dut 3: ACT hard sigmoid, W=(127,127), B=0
// Expected results come from an arithmetic model of the layer.
module tb_nn_output_layer;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [15:0] in_data;
    logic out_ready;

    logic [NDUT-1:0]      rdy;
    logic [NDUT-1:0]      ov;
    logic [NDUT-1:0]      bsy;
    logic [NDUT-1:0][7:0] od;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        nn_output_layer_if #(.N_IN(2), .N_OUT(1), .DW(8)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign rdy[g]        = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out_data;

        nn_output_layer #(
            .N_IN   (2),
            .N_OUT  (1),
            .DW     (8),
            .FRAC   (4),
            .ACT    ((g == 0) ? 0 : g - 1),
            .W_INIT ((g == 0) ? 16'hEC18 : 16'h7F7F),
            .B_INIT ((g == 0) ? 8'hFC : 8'h00)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .busy (bsy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int floor_div(input int p, input int d);
        int r;
        r = p % d;
        if (r < 0) r += d;
        return (p - r) / d;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic logic [7:0] model(input int cfg, input logic [15:0] din);
        int a0, a1, w0, w1, b, s, y;
        a0 = int'($signed(din[7:0]));
        a1 = int'($signed(din[15:8]));
        if (cfg == 0) begin
            w0 = 24;  w1 = -20; b = -4;
        end else begin
            w0 = 127; w1 = 127; b = 0;
        end
        s = clamp(floor_div(a0 * w0, 16) + floor_div(a1 * w1, 16) + b, -128, 127);
        case (cfg)
            2:       y = (s < 0) ? 0 : s;
            3:       y = clamp(floor_div(s, 4) + 8, 0, 16);
            default: y = s;
        endcase
        return 8'(y);
    endfunction

    // One transaction with out_ready high. Starts and ends at a negedge with
    // all instances idle. lat = edges after the accept edge until out_valid
    // (-1 if it never came within the budget).
    task automatic run_one(input logic [15:0] din, output logic [NDUT-1:0][7:0] res,
                           output int lat);
        lat       = -1;
        res       = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = din;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); @(negedge clk);
            if (ov[0]) begin
                lat = e;
                res = od;
                break;
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int g = 0; g < NDUT; g++) begin
            total++; if (rdy[g] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", g, rdy[g]); end
            total++; if (ov[g] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", g, ov[g]); end
            total++; if (od[g] !== 8'h00) begin bad++; $display("FAIL reset_out_data dut%0d: got %0d want 0", g, od[g]); end
            total++; if (bsy[g] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", g, bsy[g]); end
        end
    endtask

    task automatic test_basic();
        logic [NDUT-1:0][7:0] res;
        int lat;
        run_one(16'h0010, res, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++; if (res[0] !== 8'd20) begin bad++; $display("FAIL basic_dut0: got %0d want 20", $signed(res[0])); end
        for (int g = 1; g < NDUT; g++) begin
            total++;
            if (res[g] !== model(g, 16'h0010)) begin
                bad++; $display("FAIL basic dut%0d: got %0d want %0d", g, $signed(res[g]), $signed(model(g, 16'h0010)));
            end
        end
    endtask

    task automatic test_saturation();
        logic [NDUT-1:0][7:0] res;
        int lat;
        run_one(16'h7F7F, res, lat);
        total++; if (res[1] !== 8'd127) begin bad++; $display("FAIL sat_dut1: got %0d want 127", $signed(res[1])); end
        for (int g = 0; g < NDUT; g++) begin
            total++;
            if (res[g] !== model(g, 16'h7F7F)) begin
                bad++; $display("FAIL sat dut%0d: got %0d want %0d", g, $signed(res[g]), $signed(model(g, 16'h7F7F)));
            end
        end
    endtask

    task automatic test_activation();
        logic [NDUT-1:0][7:0] res;
        int lat;
        run_one(16'h7F80, res, lat);
        total++; if (res[1] !== 8'hF8) begin bad++; $display("FAIL act_ident: got %0d want -8", $signed(res[1])); end
        total++; if (res[2] !== 8'd0)  begin bad++; $display("FAIL act_relu: got %0d want 0", $signed(res[2])); end
        total++; if (res[3] !== 8'd6)  begin bad++; $display("FAIL act_hsig: got %0d want 6", $signed(res[3])); end
        total++;
        if (res[0] !== model(0, 16'h7F80)) begin
            bad++; $display("FAIL act dut0: got %0d want %0d", $signed(res[0]), $signed(model(0, 16'h7F80)));
        end
    endtask

    task automatic test_random();
        logic [NDUT-1:0][7:0] res;
        logic [15:0] din;
        int lat;
        for (int i = 0; i < 16; i++) begin
            din = 16'($urandom());
            run_one(din, res, lat);
            total++; if (lat !== 4) begin bad++; $display("FAIL rand_latency vec%0d: got %0d want 4", i, lat); end
            for (int g = 0; g < NDUT; g++) begin
                total++;
                if (res[g] !== model(g, din)) begin
                    bad++; $display("FAIL rand vec%0d in=%h dut%0d: got %0d want %0d", i, din, g, $signed(res[g]), $signed(model(g, din)));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [NDUT-1:0][7:0] res;
        logic [15:0] din;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h5A3C;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            total++; if (bsy[g] !== 1'b1) begin bad++; $display("FAIL midrst_busy_before dut%0d: got %b want 1", g, bsy[g]); end
        end
        rst = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            total++; if (rdy[g] !== 1'b1) begin bad++; $display("FAIL midrst_in_ready dut%0d: got %b want 1", g, rdy[g]); end
            total++; if (ov[g] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid dut%0d: got %b want 0", g, ov[g]); end
            total++; if (od[g] !== 8'h00) begin bad++; $display("FAIL midrst_out_data dut%0d: got %0d want 0", g, od[g]); end
            total++; if (bsy[g] !== 1'b0) begin bad++; $display("FAIL midrst_busy dut%0d: got %b want 0", g, bsy[g]); end
        end
        repeat (4) @(negedge clk);
        total++; if (ov !== '0) begin bad++; $display("FAIL midrst_hold_valid: got %b want 0000", ov); end
        rst = 1'b1;
        @(negedge clk);
        din = 16'($urandom());
        run_one(din, res, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL midrst_restart_latency: got %0d want 4", lat); end
        for (int g = 0; g < NDUT; g++) begin
            total++;
            if (res[g] !== model(g, din)) begin
                bad++; $display("FAIL midrst_restart dut%0d: got %0d want %0d", g, $signed(res[g]), $signed(model(g, din)));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NDUT-1:0][7:0] expv;
        logic [15:0] din;
        int waited;
        din = 16'($urandom());
        for (int g = 0; g < NDUT; g++) expv[g] = model(g, din);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = din;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!ov[0] && waited < 20) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_timeout: out_valid=%b after %0d cycles, want 1", ov[0], waited); end
        for (int c = 0; c < 11; c++) begin
            for (int g = 0; g < NDUT; g++) begin
                total++;
                if (ov[g] !== 1'b1 || od[g] !== expv[g]) begin
                    bad++; $display("FAIL bp_hold c%0d dut%0d: valid=%b data=%0d want valid=1 data=%0d", c, g, ov[g], $signed(od[g]), $signed(expv[g]));
                end
            end
            total++; if (rdy !== '0) begin bad++; $display("FAIL bp_in_ready c%0d: got %b want 0000", c, rdy); end
            if (c < 10) begin
                in_valid = c[0];
                in_data  = 16'($urandom());
                @(posedge clk); @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (ov !== '0) begin bad++; $display("FAIL bp_release_valid: got %b want 0000", ov); end
        total++; if (rdy !== '1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1111", rdy); end
        @(posedge clk); @(negedge clk);
        total++; if (bsy !== '0) begin bad++; $display("FAIL bp_no_capture: busy=%b want 0000", bsy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec [3];
        int when [3];
        logic [NDUT-1:0][7:0] got_data [3];
        int sent;
        int got;
        logic accept;
        for (int i = 0; i < 3; i++) vec[i] = 16'($urandom());
        sent      = 0;
        got       = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vec[0];
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            if (ov[0]) begin
                when[got]     = cyc;
                got_data[got] = od;
                got++;
            end
            accept = rdy[0] && in_valid;
            @(posedge clk); @(negedge clk);
            if (accept) begin
                sent++;
                if (sent < 3) in_data = vec[sent];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++; if (got !== 3) begin bad++; $display("FAIL b2b_count: got %0d results want 3", got); end
        for (int i = 0; i < got; i++) begin
            for (int g = 0; g < NDUT; g++) begin
                total++;
                if (got_data[i][g] !== model(g, vec[i])) begin
                    bad++; $display("FAIL b2b res%0d dut%0d: got %0d want %0d", i, g, $signed(got_data[i][g]), $signed(model(g, vec[i])));
                end
            end
            if (i > 0) begin
                total++;
                if (when[i] - when[i-1] !== 6) begin
                    bad++; $display("FAIL b2b_spacing res%0d: got %0d cycles want 6", i, when[i] - when[i-1]);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_basic();
        test_saturation();
        test_activation();
        test_mid_reset();
        test_random();
        test_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
